// File: rtl/serialtopar_rx_if.sv
// Lane-side bundle between a serial lane and its receive deserializer.
// The slave modport is the deserializer; the master side drives the serial
// bit and consumes the recovered bytes.
interface serialtopar_rx_if;
    logic       serial_in;   // lane bit, MSB of each byte first
    logic [7:0] data_out;    // last received non-comma byte
    logic       valid_out;   // 1 = data byte, 0 = idle comma
    logic       byte_stb;    // one-cycle pulse per byte boundary while locked
    logic       active;      // lane locked

    modport master (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  byte_stb,
        input  active
    );

    modport slave (
        input  serial_in,
        output data_out,
        output valid_out,
        output byte_stb,
        output active
    );
endinterface

// File: rtl/serialtopar_rx.sv
// Receive-side lane deserializer. Shifts in one bit per clock, hunts for
// the comma character bit-by-bit, confirms alignment over LOCK_COUNT
// consecutive byte-aligned commas, then delivers each received byte with a
// valid flag and a per-byte strobe. Once locked, alignment is frozen until
// reset.
module serialtopar_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    serialtopar_rx_if.slave  lane
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_t      state_q,     state_d;
    logic [7:0]  sr_q;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [3:0]  comma_cnt_q, comma_cnt_d;
    logic [7:0]  data_q,      data_d;
    logic        valid_q,     valid_d;
    logic        stb_q,       stb_d;

    // The window already includes the bit being sampled this cycle, so the
    // oldest shift-register bit never takes part in matching.
    logic [7:0]  win;
    logic [7:0]  bit_eq;
    logic        comma_hit;
    logic        boundary;
    logic        unused_sr_msb;

    assign win           = {sr_q[6:0], lane.serial_in};
    assign unused_sr_msb = sr_q[7];
    assign boundary      = (bit_cnt_q == 3'd7);

    // Per-bit equality against the comma; a full match needs all eight.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
            assign bit_eq[gi] = ~(win[gi] ^ COMMA[gi]);
        end
    endgenerate

    assign comma_hit = &bit_eq;

    // Serial shift register: free-running apart from reset.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr_q <= 8'h00;
        end else begin
            sr_q <= win;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            stb_q       <= stb_d;
        end
    end

    // Next-state and output decode. The bit counter free-runs; finding a
    // comma in HUNT re-phases it so that the next LSB lands on count 7.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        stb_d       = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                if (comma_hit) begin
                    state_d     = ST_ALIGN;
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 4'd1;
                end
            end

            ST_ALIGN: begin
                if (boundary) begin
                    if (comma_hit) begin
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        // The locking comma itself produces no strobe.
                        if ((comma_cnt_q + 4'd1) == LOCK_CNT) begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        // A false match in HUNT is dropped here.
                        state_d     = ST_HUNT;
                        comma_cnt_d = 4'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                // Alignment is frozen: commas straddling bytes are never seen.
                if (boundary) begin
                    stb_d = 1'b1;
                    if (comma_hit) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = win;
                        valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = ST_HUNT;
                comma_cnt_d = 4'd0;
            end
        endcase
    end

    assign lane.data_out  = data_q;
    assign lane.valid_out = valid_q;
    assign lane.byte_stb  = stb_q;
    assign lane.active    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_serialtopar_rx.sv
// Directed bench for the lane deserializer: reset, aligned and offset lock,
// data delivery, false-comma recovery and reset while locked.
module tb_serialtopar_rx;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;

    serialtopar_rx_if lane_if ();

    serialtopar_rx #(
        .COMMA      (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .lane   (lane_if)
    );

    always #5 clk_8f = ~clk_8f;

    int checks   = 0;
    int failures = 0;
    int stb_seen = 0;

    logic [7:0] bc_v  = 8'hBC;
    logic [7:0] a5_v  = 8'hA5;
    logic [2:0] rnd_v;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let the posedge sample it, then observe just after.
    task automatic step(input logic b);
        lane_if.serial_in = b;
        @(posedge clk_8f);
        #1;
        if (lane_if.byte_stb === 1'b1) stb_seen++;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    // All but the LSB of a byte.
    task automatic send_head(input logic [7:0] v);
        for (int i = 7; i >= 1; i--) step(v[i]);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
    endtask

    initial begin
        lane_if.serial_in = 1'b0;

        // T1: reset held 3 cycles with random serial data
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lane_if.serial_in = 1'($urandom_range(0, 1));
            @(posedge clk_8f);
            #1;
            chk("t1_rst_data",   lane_if.data_out,         8'h00);
            chk("t1_rst_valid",  8'(lane_if.valid_out),    8'd0);
            chk("t1_rst_stb",    8'(lane_if.byte_stb),     8'd0);
            chk("t1_rst_active", 8'(lane_if.active),       8'd0);
        end
        reset = 1'b0;

        // T2: four aligned commas from bit 0
        stb_seen = 0;
        step(bc_v[7]);
        chk("t1_rel_data",   lane_if.data_out,      8'h00);
        chk("t1_rel_valid",  8'(lane_if.valid_out), 8'd0);
        chk("t1_rel_active", 8'(lane_if.active),    8'd0);
        for (int i = 6; i >= 0; i--) step(bc_v[i]);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_head(8'hBC);
        chk("t2_active_bit31", 8'(lane_if.active), 8'd0);
        step(bc_v[0]);
        chk("t2_active_bit32", 8'(lane_if.active), 8'd1);
        chk("t2_no_stb_prelock", 8'(stb_seen), 8'd0);
        chk("t2_lock_stb", 8'(lane_if.byte_stb), 8'd0);

        // T3: three random bits, then six commas on a 3-bit offset
        pulse_reset();
        stb_seen = 0;
        rnd_v = 3'($urandom_range(0, 7));
        step(rnd_v[2]);
        step(rnd_v[1]);
        step(rnd_v[0]);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_head(8'hBC);
        chk("t3_active_pre", 8'(lane_if.active), 8'd0);
        step(bc_v[0]);
        chk("t3_active_lock", 8'(lane_if.active), 8'd1);
        chk("t3_no_stb_prelock", 8'(stb_seen), 8'd0);
        send_head(8'hBC);
        chk("t3_stb_mid", 8'(lane_if.byte_stb), 8'd0);
        step(bc_v[0]);
        chk("t3_stb_c5",   8'(lane_if.byte_stb),  8'd1);
        chk("t3_valid_c5", 8'(lane_if.valid_out), 8'd0);
        chk("t3_data_c5",  lane_if.data_out,      8'h00);
        send_byte(8'hBC);
        chk("t3_stb_c6", 8'(lane_if.byte_stb), 8'd1);

        // T4: data, comma, data after lock
        stb_seen = 0;
        step(1'b0);
        chk("t4_stb_gap", 8'(lane_if.byte_stb), 8'd0);
        for (int i = 6; i >= 0; i--) step(1'(8'h5A >> i));
        chk("t4_data_5a",  lane_if.data_out,      8'h5A);
        chk("t4_valid_5a", 8'(lane_if.valid_out), 8'd1);
        chk("t4_stb_5a",   8'(lane_if.byte_stb),  8'd1);
        send_byte(8'hBC);
        chk("t4_data_bc",  lane_if.data_out,      8'h5A);
        chk("t4_valid_bc", 8'(lane_if.valid_out), 8'd0);
        send_byte(8'hFF);
        chk("t4_data_ff",  lane_if.data_out,      8'hFF);
        chk("t4_valid_ff", 8'(lane_if.valid_out), 8'd1);
        chk("t4_stb_count", 8'(stb_seen), 8'd3);

        // T5: two commas then a non-comma drops back to HUNT
        pulse_reset();
        send_byte(8'hBC);
        chk("t5_cnt_1", 8'(dut.comma_cnt_q), 8'd1);
        send_byte(8'hBC);
        chk("t5_cnt_2", 8'(dut.comma_cnt_q), 8'd2);
        send_byte(8'h00);
        chk("t5_cnt_0",     8'(dut.comma_cnt_q), 8'd0);
        chk("t5_active_0",  8'(lane_if.active),  8'd0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("t5_active_3c", 8'(lane_if.active), 8'd0);
        send_byte(8'hBC);
        chk("t5_relock", 8'(lane_if.active), 8'd1);

        // T6: reset in mid-ACTIVE, then relock from scratch
        send_byte(8'h3C);
        chk("t6_data_3c",  lane_if.data_out,      8'h3C);
        chk("t6_valid_3c", 8'(lane_if.valid_out), 8'd1);
        for (int i = 7; i >= 4; i--) step(a5_v[i]);
        chk("t6_bitcnt_4", 8'(dut.bit_cnt_q), 8'd4);
        pulse_reset();
        chk("t6_active_rst", 8'(lane_if.active),    8'd0);
        chk("t6_valid_rst",  8'(lane_if.valid_out), 8'd0);
        chk("t6_data_rst",   lane_if.data_out,      8'h00);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("t6_active_3c", 8'(lane_if.active), 8'd0);
        send_byte(8'hBC);
        chk("t6_relock", 8'(lane_if.active), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
